// File: rtl/minterm_sweeper.sv
// rtl/minterm_sweeper.sv - N-input truth-table engine with live evaluation and row sweep
module minterm_sweeper #(
  parameter int N = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [(1<<N)-1:0]   mask_in,
  input  logic                mode_in,
  input  logic                start,
  input  logic [N-1:0]        x_in,
  output logic                s_live,
  output logic                busy,
  output logic                sweep_valid,
  output logic [N-1:0]        sweep_idx,
  output logic                sweep_s,
  output logic [N:0]          ones_count,
  output logic                done
);

  localparam int M = 1 << N;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [M-1:0]   mask_q;
  logic           mode_q;
  logic           s_live_q;
  logic           sweep_valid_q;
  logic [N-1:0]   idx_q;
  logic [N:0]     count_q;
  logic           done_q;

  // PoS lists maxterms, so the function is the complement of the listed bit.
  logic f_sweep;
  logic f_live;
  logic last_row;

  assign f_sweep  = mode_q ^ mask_q[idx_q];
  assign f_live   = mode_q ^ mask_q[x_in];
  assign last_row = &idx_q;

  // State register; reset aborts any sweep in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a simultaneous load suppresses start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && !load) state_d = SWEEP;
      SWEEP:   if (last_row) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the state register.
  always_comb begin
    busy = 1'b0;
    case (state_q)
      SWEEP:   busy = 1'b1;
      DONE:    busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Datapath: live evaluation every cycle, mask capture and sweep counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q        <= '0;
      mode_q        <= 1'b0;
      s_live_q      <= 1'b0;
      sweep_valid_q <= 1'b0;
      idx_q         <= '0;
      count_q       <= '0;
      done_q        <= 1'b0;
    end else begin
      s_live_q <= f_live;
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (load) begin
            mask_q <= mask_in;
            mode_q <= mode_in;
          end else if (start) begin
            count_q       <= '0;
            idx_q         <= '0;
            sweep_valid_q <= 1'b1;
          end
        end
        SWEEP: begin
          count_q <= count_q + (N+1)'(f_sweep);
          if (last_row) begin
            sweep_valid_q <= 1'b0;
            done_q        <= 1'b1;
          end else begin
            idx_q <= idx_q + N'(1);
          end
        end
        DONE: begin
          done_q <= 1'b0;
        end
        default: begin
          done_q <= 1'b0;
        end
      endcase
    end
  end

  // The row value is only meaningful while a sweep is presenting rows.
  assign sweep_s     = sweep_valid_q & f_sweep;
  assign s_live      = s_live_q;
  assign sweep_valid = sweep_valid_q;
  assign sweep_idx   = idx_q;
  assign ones_count  = count_q;
  assign done        = done_q;

endmodule

// File: tb/tb_minterm_sweeper.sv
// tb/tb_minterm_sweeper.sv - directed self-checking bench for minterm_sweeper
module tb_minterm_sweeper;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // N=3 instance
  logic       load3, start3, mode3;
  logic [7:0] mask3;
  logic [2:0] x3;
  logic       s_live3, busy3, valid3, s3, done3;
  logic [2:0] idx3;
  logic [3:0] cnt3;

  // N=4 instance
  logic        load4, start4, mode4;
  logic [15:0] mask4;
  logic [3:0]  x4;
  logic        s_live4, busy4, valid4, s4, done4;
  logic [3:0]  idx4;
  logic [4:0]  cnt4;

  minterm_sweeper #(.N(3)) dut3 (
    .clk(clk), .rst(rst), .load(load3), .mask_in(mask3), .mode_in(mode3),
    .start(start3), .x_in(x3), .s_live(s_live3), .busy(busy3),
    .sweep_valid(valid3), .sweep_idx(idx3), .sweep_s(s3),
    .ones_count(cnt3), .done(done3)
  );

  minterm_sweeper #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .load(load4), .mask_in(mask4), .mode_in(mode4),
    .start(start4), .x_in(x4), .s_live(s_live4), .busy(busy4),
    .sweep_valid(valid4), .sweep_idx(idx4), .sweep_s(s4),
    .ones_count(cnt4), .done(done4)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] mask;
    logic       mode;
    logic [7:0] rows;   // hand-computed f for rows 7..0
    logic [3:0] cnt;
  } vec_t;

  vec_t vecs[5];

  // Load, start, then follow all 8 rows, the done cycle and the return to idle.
  task automatic sweep3(input vec_t v);
    @(negedge clk); load3 = 1'b1; mask3 = v.mask; mode3 = v.mode;
    @(negedge clk); load3 = 1'b0; start3 = 1'b1;
    @(negedge clk); start3 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("sw_valid", 32'(valid3), 32'd1);
      chk("sw_idx",   32'(idx3),   32'(i));
      chk("sw_s",     32'(s3),     32'(v.rows[i]));
      chk("sw_busy",  32'(busy3),  32'd1);
      chk("sw_done",  32'(done3),  32'd0);
      @(negedge clk);
    end
    chk("done_pulse", 32'(done3),  32'd1);
    chk("done_valid", 32'(valid3), 32'd0);
    chk("done_busy",  32'(busy3),  32'd1);
    chk("done_cnt",   32'(cnt3),   32'(v.cnt));
    @(negedge clk);
    chk("idle_done", 32'(done3), 32'd0);
    chk("idle_busy", 32'(busy3), 32'd0);
    chk("idle_cnt",  32'(cnt3),  32'(v.cnt));
  endtask

  initial begin
    vecs[0] = '{mask: 8'hAA, mode: 1'b0, rows: 8'hAA, cnt: 4'd4};
    vecs[1] = '{mask: 8'hAA, mode: 1'b1, rows: 8'h55, cnt: 4'd4};
    vecs[2] = '{mask: 8'hFF, mode: 1'b0, rows: 8'hFF, cnt: 4'd8};
    vecs[3] = '{mask: 8'h00, mode: 1'b1, rows: 8'hFF, cnt: 4'd8};
    vecs[4] = '{mask: 8'h96, mode: 1'b0, rows: 8'h96, cnt: 4'd4};

    // Reset held for two cycles with start asserted.
    rst = 1'b1; load3 = 1'b0; start3 = 1'b1; mask3 = 8'hFF; mode3 = 1'b1; x3 = 3'd0;
    load4 = 1'b0; start4 = 1'b1; mask4 = 16'h0; mode4 = 1'b0; x4 = 4'd0;
    @(negedge clk); @(negedge clk);
    chk("rst_busy",  32'(busy3),   32'd0);
    chk("rst_valid", 32'(valid3),  32'd0);
    chk("rst_idx",   32'(idx3),    32'd0);
    chk("rst_s",     32'(s3),      32'd0);
    chk("rst_slive", 32'(s_live3), 32'd0);
    chk("rst_cnt",   32'(cnt3),    32'd0);
    chk("rst_done",  32'(done3),   32'd0);
    chk("rst_busy4", 32'(busy4),   32'd0);
    rst = 1'b0; start3 = 1'b0; start4 = 1'b0;
    @(negedge clk);
    chk("post_rst_busy",  32'(busy3),  32'd0);
    chk("post_rst_valid", 32'(valid3), 32'd0);

    // Full sweeps from the vector table.
    for (int k = 0; k < 5; k++) sweep3(vecs[k]);

    // Mid-sweep load is ignored, mid-sweep reset aborts.
    @(negedge clk); load3 = 1'b1; mask3 = 8'hAA; mode3 = 1'b0;
    @(negedge clk); load3 = 1'b0; start3 = 1'b1;
    @(negedge clk); start3 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("mid_idx", 32'(idx3), 32'(i));
      @(negedge clk);
      if (i == 2) begin load3 = 1'b1; mask3 = 8'h00; end
    end
    // Load was presented during the idx=3 cycle.
    load3 = 1'b0;
    chk("mid_idx4", 32'(idx3), 32'd4);
    chk("mid_s4",   32'(s3),   32'd0);
    @(negedge clk);
    chk("mid_idx5", 32'(idx3), 32'd5);
    chk("mid_s5",   32'(s3),   32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy",  32'(busy3),  32'd0);
    chk("abort_cnt",   32'(cnt3),   32'd0);
    chk("abort_valid", 32'(valid3), 32'd0);
    chk("abort_done",  32'(done3),  32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_nodone", 32'(done3), 32'd0);
    end

    // Live path with mask 8'hAA, SoP.
    load3 = 1'b1; mask3 = 8'hAA; mode3 = 1'b0;
    @(negedge clk); load3 = 1'b0; x3 = 3'b101;
    @(negedge clk);
    chk("live_101", 32'(s_live3), 32'd1);
    x3 = 3'b110;
    @(negedge clk);
    chk("live_110", 32'(s_live3), 32'd0);
    // Load and start together: load wins.
    load3 = 1'b1; start3 = 1'b1; mask3 = 8'h0F; x3 = 3'b000;
    @(negedge clk);
    load3 = 1'b0; start3 = 1'b0;
    chk("ls_busy",  32'(busy3),  32'd0);
    chk("ls_valid", 32'(valid3), 32'd0);
    @(negedge clk);
    chk("ls_busy2", 32'(busy3),   32'd0);
    chk("ls_live",  32'(s_live3), 32'd1);
    x3 = 3'b100;
    @(negedge clk);
    chk("ls_live4", 32'(s_live3), 32'd0);

    // N=4 sweep, mask 16'h8001.
    load4 = 1'b1; mask4 = 16'h8001; mode4 = 1'b0;
    @(negedge clk); load4 = 1'b0; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("n4_valid", 32'(valid4), 32'd1);
      chk("n4_idx",   32'(idx4),   32'(i));
      chk("n4_s",     32'(s4),     (i == 0 || i == 15) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    chk("n4_done",  32'(done4),  32'd1);
    chk("n4_valid_end", 32'(valid4), 32'd0);
    chk("n4_cnt",   32'(cnt4),   32'd2);
    @(negedge clk);
    chk("n4_idle_busy", 32'(busy4), 32'd0);
    chk("n4_idle_done", 32'(done4), 32'd0);
    chk("n4_idle_cnt",  32'(cnt4),  32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
